// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM encoding and sizing helpers for serial_adder
//
// Purpose: state encoding for the bit-serial adder FSM and the bit-counter
//          width helper, imported by the interface consumers and the top.
// Ports:   none (package).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle for serial_adder
//
// Purpose: groups the start/operand request and the busy/done/result
//          response of the serial adder.
// Signals: start, a[WIDTH], b[WIDTH], cin   (master -> slave)
//          busy, done, sum[WIDTH], cout     (slave -> master)
//          ovf                              (slave -> master, only when
//                                            SERIAL_ADDER_OVF_EN is defined)
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_fa_with_ha.sv
// rtl/serial_adder_fa_with_ha.sv - single-bit full adder built from two half adders
//
// Purpose: the shared one-bit full adder cell used by the serial adder.
// Ports:   A, B, Cin (inputs), S (sum), Cout (carry out).
module fa_with_ha (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic ha1_s;
  logic ha1_c;
  logic ha2_c;

  // First half adder on A/B, second folds in Cin; carries are ORed.
  assign ha1_s = A ^ B;
  assign ha1_c = A & B;
  assign S     = ha1_s ^ Cin;
  assign ha2_c = ha1_s & Cin;
  assign Cout  = ha1_c | ha2_c;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder sequencing one full-adder cell
//
// Purpose: captures two operands and a carry-in on start, feeds one bit pair
//          per clock (LSB first) through fa_with_ha and shifts the sum bits
//          into a result register. done pulses WIDTH edges after acceptance.
// Ports:   clk     system clock
//          rst_n   synchronous active-low reset
//          bus     serial_adder_if.slave (start, a, b, cin / busy, done,
//                  sum, cout, and ovf when SERIAL_ADDER_OVF_EN is defined)
// Options: SERIAL_ADDER_OVF_EN adds the registered signed-overflow flag ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_s;
  logic             fa_cout;
  logic             last_step;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  fa_with_ha u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        // DONE accepts a new start exactly like IDLE so back-to-back
        // requests lose no cycle.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            carry_q <= bus.cin;
            cnt     <= '0;
            busy_q  <= 1'b1;
            state   <= ADD;
          end else begin
            state <= IDLE;
          end
        end
        ADD: begin
          // LSB-first: after WIDTH shifts the first sum bit lands in sum_q[0].
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          carry_q <= fa_cout;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          cnt     <= cnt + 1'b1;
          if (last_step) begin
            cout_q <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // Carry into the MSB differs from carry out of it on signed overflow.
            ovf_q  <= carry_q ^ fa_cout;
`endif
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W8)) bus8 ();
  serial_adder_if #(.WIDTH(W4)) bus4 ();

  serial_adder #(.WIDTH(W8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(W4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [10];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation on the 8-bit DUT starting from IDLE/DONE; returns the
  // observed result and the number of busy cycles seen before done.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         output logic [7:0] sum, output logic cout, output logic ovf,
                         output int busy_cycles, output bit got_done);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    busy_cycles = 0;
    got_done = 1'b0;
    sum = '0; cout = 1'b0; ovf = 1'b0;
    for (int i = 0; i < W8 + 4 && !got_done; i++) begin
      if (bus8.done) begin
        got_done = 1'b1;
        sum  = bus8.sum;
        cout = bus8.cout;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  = bus8.ovf;
`endif
        check("busy_low_with_done", {63'd0, bus8.busy}, 64'd0);
      end else begin
        if (bus8.busy) busy_cycles++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [7:0] s;
    logic       c;
    logic       o;
    int         bc;
    bit         gd;
    int         n_done;
    int         n;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[9] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state8", {53'd0, bus8.busy, bus8.done, bus8.cout, bus8.sum}, 64'd0);
    check("reset_state4", {57'd0, bus4.busy, bus4.done, bus4.cout, bus4.sum}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset_ovf", {63'd0, bus8.ovf}, 64'd0);
`endif
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_op8(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, o, bc, gd);
      check($sformatf("v%0d_done", i), {63'd0, gd}, 64'd1);
      check($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(W8));
      check($sformatf("v%0d_sum", i), {56'd0, s}, {56'd0, vecs[i].sum});
      check($sformatf("v%0d_cout", i), {63'd0, c}, {63'd0, vecs[i].cout});
`ifdef SERIAL_ADDER_OVF_EN
      check($sformatf("v%0d_ovf", i), {63'd0, o}, {63'd0, vecs[i].ovf});
`endif
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {63'd0, bus8.done}, 64'd0);
      check($sformatf("v%0d_sum_held", i), {56'd0, bus8.sum}, {56'd0, vecs[i].sum});
    end

    // Exhaustive 4-bit sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          logic [4:0] exp5;
          bit got;
          exp5 = 5'(a + b + ci);
          @(negedge clk);
          bus4.a = 4'(a); bus4.b = 4'(b); bus4.cin = ci[0]; bus4.start = 1'b1;
          @(negedge clk);
          bus4.start = 1'b0;
          got = 1'b0;
          for (int k = 0; k < W4 + 4 && !got; k++) begin
            if (bus4.done) got = 1'b1;
            else @(negedge clk);
          end
          check($sformatf("sweep4_%0d_%0d_%0d", a, b, ci),
                {58'd0, got, bus4.cout, bus4.sum}, {58'd0, 1'b1, exp5});
        end
      end
    end

    // start and operands changed on the third ADD cycle are ignored
    @(negedge clk);
    bus8.a = 8'h0F; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    n_done = 0; s = '0; c = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (bus8.done) begin
        n_done++;
        s = bus8.sum;
        c = bus8.cout;
      end
      @(negedge clk);
    end
    check("ignore_start_done_count", 64'(n_done), 64'd1);
    check("ignore_start_sum", {55'd0, c, s}, {55'd0, 1'b0, 8'h10});
    check("ignore_start_idle", {63'd0, bus8.busy}, 64'd0);

    // Reset on the fourth ADD cycle aborts the operation
    @(negedge clk);
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_clear", {53'd0, bus8.busy, bus8.done, bus8.cout, bus8.sum}, 64'd0);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus8.done) n_done++;
      @(negedge clk);
    end
    check("midreset_no_done", 64'(n_done), 64'd0);
    run_op8(8'h12, 8'h34, 1'b1, s, c, o, bc, gd);
    check("midreset_recover", {54'd0, gd, c, s}, {54'd0, 1'b1, 1'b0, 8'h47});

    // start held high: one operation every WIDTH+1 cycles
    repeat (2) @(negedge clk);
    bus8.start = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus8.a = vecs[j].a; bus8.b = vecs[j].b; bus8.cin = vecs[j].cin;
      gd = 1'b0;
      n = 0;
      while (n < 14 && !gd) begin
        @(negedge clk);
        n++;
        if (bus8.done) gd = 1'b1;
      end
      check($sformatf("b2b%0d_period", j), 64'(n), 64'(W8 + 1));
      check($sformatf("b2b%0d_result", j), {54'd0, gd, bus8.cout, bus8.sum},
            {54'd0, 1'b1, vecs[j].cout, vecs[j].sum});
    end
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
